bus_wr_arbiter: RTL and testbench
=================================

# bus_wr_arbiter

Shares the single system-bus write port (AW + W channels) among up to NUM_REQ write controllers (FC result writer, conv/pool writers, etc.). Round-robin arbitration at burst granularity: a grant covers one address phase plus all data beats of that burst, released only on the bus's last-beat indication. Sits between the per-layer write controllers and the bus interconnect. Reports per-burst completion and beat-count errors.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 28, write address width
- DATA_W, 32, write data width
- LEN_W, 4, burst length field width (beats = awlen+1)
- TIMEOUT_CYC, 1024, data-phase watchdog limit (used only with WR_ARB_TIMEOUT_EN)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_awvalid  in  NUM_REQ  per-requester burst request
- req_awaddr  in  NUM_REQ×ADDR_W  per-requester burst address
- req_awlen  in  NUM_REQ×LEN_W  per-requester burst length
- req_awuser_id  in  NUM_REQ×4  per-requester transaction ID
- req_awuser_ap  in  NUM_REQ  per-requester auto-precharge hint
- req_awready  out  NUM_REQ  one-hot pulse: address accepted by bus
- req_wdata  in  NUM_REQ×DATA_W  per-requester write data
- req_wstrb  in  NUM_REQ×4  per-requester byte strobes
- req_wready  out  NUM_REQ  bus wready routed to granted requester only
- req_wlast  out  NUM_REQ  bus last-beat routed to granted requester only
- bus_awvalid / bus_awaddr / bus_awlen / bus_awuser_id / bus_awuser_ap  out  1/ADDR_W/LEN_W/4/1  bus address channel
- bus_awready  in  1  bus address accept
- bus_wdata / bus_wstrb  out  DATA_W/4  bus data channel
- bus_wready  in  1  bus data beat accept
- bus_wuser_id / bus_wuser_last  in  4/1  ID and last flag of current beat
- grant  out  NUM_REQ  one-hot current owner (0 when idle)
- burst_done  out  1  one-cycle pulse at burst release
- len_err  out  1  sticky: beat count ≠ awlen+1 at release; cleared only by reset

## Operation
- FSM: IDLE, ADDR, DATA (+ ABORT with macro).
- IDLE: if any req_awvalid, pick first set index at or after rr_ptr (wrapping); latch grant, awaddr/awlen/id/ap of winner; → ADDR.
- ADDR: bus_awvalid=1 with latched fields; on bus_awready: req_awready[g]=1 for that cycle, beat_cnt←0, → DATA.
- DATA: bus_wdata/bus_wstrb = winner's req_wdata/req_wstrb (combinational mux); req_wready[g]=bus_wready, req_wlast[g]=bus_wready&bus_wuser_last; beat_cnt increments on each bus_wready.
- Release: bus_wready & bus_wuser_last & bus_wuser_id==latched id → burst_done=1, len_err|=(beat_cnt+1≠awlen+1), rr_ptr←g+1 mod NUM_REQ, grant←0, → IDLE.
- Last flag with mismatching ID: ignored for release (beat still counted).
- beat_cnt width LEN_W+1; saturates at all-ones.
- Requesters must hold awvalid and fields stable until awready; arbiter uses latched copies regardless.
- Non-granted outputs: req_awready, req_wready, req_wlast all 0.

## Timing
- Reset: FSM IDLE, rr_ptr=0, grant=0, all bus_* outputs 0, req_* outputs 0, burst_done=0, len_err=0.
- Request → bus_awvalid: 1 cycle (IDLE decision registered).
- Release → next bus_awvalid: 2 cycles (back through IDLE); no back-to-back overlap.
- Simultaneous requests: one winner per IDLE cycle; a requester never waits more than NUM_REQ−1 bursts.
- bus_wready paths are combinational to requesters (zero latency).
- Reset mid-burst: immediate return to IDLE, all outputs 0, no burst_done.

## Configuration
- WR_ARB_TIMEOUT_EN defined: counter clears on each bus_wready or awready; if it reaches TIMEOUT_CYC in ADDR or DATA → ABORT for 1 cycle: outputs 0, sticky output timeout_err=1, rr_ptr advanced, → IDLE. Port timeout_err present.
- Undefined: no watchdog, no ABORT state, no timeout_err port; grant held indefinitely.

## Structure
- Package wr_arb_pkg: state enum (IDLE, ADDR, DATA, ABORT), default widths, WID constants per requester type (FC = 4'b0110).
- Sub-module rr_pick: combinational round-robin picker (req vector + pointer → one-hot + valid).

## Test plan
- Single requester 0, awlen=3, bus_awready at cycle 2, 4 wready beats, last with matching ID → 4 beats forwarded, burst_done once, len_err=0, grant=0 after.
- Requesters 1 and 2 simultaneous, rr_ptr=0 → 1 served first, then 2; next simultaneous 1/2 round → 2 wins? No: rr_ptr=3 → wraps, 1 wins.
- awlen=3 but last after 2 beats → release, len_err=1 and stays 1 across later good bursts.
- Last flag with ID 4'h5 while granted ID 4'h6 → no release; release on later matching last.
- Reset asserted during DATA beat 2 → all outputs 0 next edge, new request served normally after deassert.
- WR_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, bus_wready stuck low → ABORT at 16th stalled cycle, timeout_err=1, next requester granted.

Source files
------------

// File: rtl/wr_arb_pkg.sv
// Shared types and defaults for the system-bus write-port arbiter.
// Transaction IDs identify the requester class that owns a burst.
package wr_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAddr  = 2'd1,
        StData  = 2'd2,
        StAbort = 2'd3
    } wr_arb_state_e;

    localparam int unsigned NumReqDef = 4;
    localparam int unsigned AddrWDef  = 28;
    localparam int unsigned DataWDef  = 32;
    localparam int unsigned LenWDef   = 4;

    localparam logic [3:0] WidFc   = 4'b0110;
    localparam logic [3:0] WidConv = 4'b0010;
    localparam logic [3:0] WidPool = 4'b0100;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping around, reported as one-hot plus index.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned PtrW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [N-1:0]    gnt_oh_o,
    output logic [PtrW-1:0] gnt_idx_o,
    output logic            valid_o
);

    always_comb begin
        logic found;
        found     = 1'b0;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned k;
            k = (32'(ptr_i) + i) % N;
            if (!found && req_i[k]) begin
                found       = 1'b1;
                gnt_oh_o[k] = 1'b1;
                gnt_idx_o   = PtrW'(k);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/bus_wr_arbiter.sv
// Burst-granular round-robin arbiter for the shared bus write port (AW + W).
// Optional data-phase watchdog enabled by defining WR_ARB_TIMEOUT_EN.
module bus_wr_arbiter import wr_arb_pkg::*; #(
    parameter int unsigned NUM_REQ = NumReqDef,
    parameter int unsigned ADDR_W  = AddrWDef,
    parameter int unsigned DATA_W  = DataWDef,
    parameter int unsigned LEN_W   = LenWDef
`ifdef WR_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_awvalid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_awaddr,
    input  logic [NUM_REQ-1:0][LEN_W-1:0]    req_awlen,
    input  logic [NUM_REQ-1:0][3:0]          req_awuser_id,
    input  logic [NUM_REQ-1:0]               req_awuser_ap,
    output logic [NUM_REQ-1:0]               req_awready,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_wdata,
    input  logic [NUM_REQ-1:0][3:0]          req_wstrb,
    output logic [NUM_REQ-1:0]               req_wready,
    output logic [NUM_REQ-1:0]               req_wlast,
    output logic                             bus_awvalid,
    output logic [ADDR_W-1:0]                bus_awaddr,
    output logic [LEN_W-1:0]                 bus_awlen,
    output logic [3:0]                       bus_awuser_id,
    output logic                             bus_awuser_ap,
    input  logic                             bus_awready,
    output logic [DATA_W-1:0]                bus_wdata,
    output logic [3:0]                       bus_wstrb,
    input  logic                             bus_wready,
    input  logic [3:0]                       bus_wuser_id,
    input  logic                             bus_wuser_last,
    output logic [NUM_REQ-1:0]               grant,
    output logic                             burst_done,
    output logic                             len_err
`ifdef WR_ARB_TIMEOUT_EN
    ,
    output logic                             timeout_err
`endif
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);
    localparam int unsigned CntW = LEN_W + 1;

    wr_arb_state_e        state_q, state_d;
    logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]      gidx_q, gidx_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [3:0]           id_q, id_d;
    logic                 ap_q, ap_d;
    logic [CntW-1:0]      beat_cnt_q, beat_cnt_d;
    logic                 len_err_q, len_err_d;
    logic                 wr_release;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [PtrW-1:0]      pick_idx;
    logic                 pick_valid;

`ifdef WR_ARB_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
    logic [ToW-1:0]       to_cnt_q, to_cnt_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 stalled;
`endif

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (32'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
    endfunction

    rr_pick #(
        .N    (NUM_REQ),
        .PtrW (PtrW)
    ) u_rr_pick (
        .req_i     (req_awvalid),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx),
        .valid_o   (pick_valid)
    );

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gidx_d        = gidx_q;
        grant_d       = grant_q;
        addr_d        = addr_q;
        len_d         = len_q;
        id_d          = id_q;
        ap_d          = ap_q;
        beat_cnt_d    = beat_cnt_q;
        len_err_d     = len_err_q;
        wr_release    = 1'b0;
        bus_awvalid   = 1'b0;
        bus_awaddr    = '0;
        bus_awlen     = '0;
        bus_awuser_id = '0;
        bus_awuser_ap = 1'b0;
        bus_wdata     = '0;
        bus_wstrb     = '0;
        req_awready   = '0;
        req_wready    = '0;
        req_wlast     = '0;
        burst_done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                    addr_d  = req_awaddr[pick_idx];
                    len_d   = req_awlen[pick_idx];
                    id_d    = req_awuser_id[pick_idx];
                    ap_d    = req_awuser_ap[pick_idx];
                    state_d = StAddr;
                end
            end
            StAddr: begin
                bus_awvalid   = 1'b1;
                bus_awaddr    = addr_q;
                bus_awlen     = len_q;
                bus_awuser_id = id_q;
                bus_awuser_ap = ap_q;
                if (bus_awready) begin
                    req_awready = grant_q;
                    beat_cnt_d  = '0;
                    state_d     = StData;
                end
            end
            StData: begin
                bus_wdata  = req_wdata[gidx_q];
                bus_wstrb  = req_wstrb[gidx_q];
                req_wready = bus_wready ? grant_q : '0;
                req_wlast  = (bus_wready && bus_wuser_last) ? grant_q : '0;
                if (bus_wready && (beat_cnt_q != '1)) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // A last flag tagged with another ID is counted but never releases the grant.
                wr_release = bus_wready && bus_wuser_last && (bus_wuser_id == id_q);
                if (wr_release) begin
                    burst_done = 1'b1;
                    // beat_cnt+1 != awlen+1 reduces to beat_cnt != awlen
                    if (beat_cnt_q != {1'b0, len_q}) begin
                        len_err_d = 1'b1;
                    end
                    rr_ptr_d = next_ptr(gidx_q);
                    grant_d  = '0;
                    state_d  = StIdle;
                end
            end
            StAbort: begin
`ifdef WR_ARB_TIMEOUT_EN
                rr_ptr_d = next_ptr(gidx_q);
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

`ifdef WR_ARB_TIMEOUT_EN
        to_cnt_d      = '0;
        timeout_err_d = timeout_err_q;
        stalled       = ((state_q == StAddr) && !bus_awready) ||
                        ((state_q == StData) && !bus_wready);
        if (stalled) begin
            if (to_cnt_q == ToW'(TIMEOUT_CYC - 1)) begin
                state_d       = StAbort;
                grant_d       = '0;
                timeout_err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            gidx_q     <= '0;
            grant_q    <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            id_q       <= '0;
            ap_q       <= 1'b0;
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gidx_q     <= gidx_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            id_q       <= id_d;
            ap_q       <= ap_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

`ifdef WR_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

    assign grant   = grant_q;
    assign len_err = len_err_q;

endmodule

// File: tb/tb_bus_wr_arbiter.sv
// Scoreboard bench for bus_wr_arbiter: stimulus pushes expected AW and W
// responses, a negedge monitor pops and compares on each bus handshake.
module tb_bus_wr_arbiter;
    import wr_arb_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 28;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]          req_awvalid = '0;
    logic [N-1:0][AW-1:0]  req_awaddr = '0;
    logic [N-1:0][LW-1:0]  req_awlen = '0;
    logic [N-1:0][3:0]     req_awuser_id = '0;
    logic [N-1:0]          req_awuser_ap = '0;
    logic [N-1:0]          req_awready;
    logic [N-1:0][DW-1:0]  req_wdata = '0;
    logic [N-1:0][3:0]     req_wstrb = '0;
    logic [N-1:0]          req_wready;
    logic [N-1:0]          req_wlast;
    logic                  bus_awvalid;
    logic [AW-1:0]         bus_awaddr;
    logic [LW-1:0]         bus_awlen;
    logic [3:0]            bus_awuser_id;
    logic                  bus_awuser_ap;
    logic                  bus_awready = 1'b0;
    logic [DW-1:0]         bus_wdata;
    logic [3:0]            bus_wstrb;
    logic                  bus_wready = 1'b0;
    logic [3:0]            bus_wuser_id = '0;
    logic                  bus_wuser_last = 1'b0;
    logic [N-1:0]          grant;
    logic                  burst_done;
    logic                  len_err;
`ifdef WR_ARB_TIMEOUT_EN
    logic                  timeout_err;
`endif

    bus_wr_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .LEN_W   (LW)
`ifdef WR_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (16)
`endif
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_awvalid    (req_awvalid),
        .req_awaddr     (req_awaddr),
        .req_awlen      (req_awlen),
        .req_awuser_id  (req_awuser_id),
        .req_awuser_ap  (req_awuser_ap),
        .req_awready    (req_awready),
        .req_wdata      (req_wdata),
        .req_wstrb      (req_wstrb),
        .req_wready     (req_wready),
        .req_wlast      (req_wlast),
        .bus_awvalid    (bus_awvalid),
        .bus_awaddr     (bus_awaddr),
        .bus_awlen      (bus_awlen),
        .bus_awuser_id  (bus_awuser_id),
        .bus_awuser_ap  (bus_awuser_ap),
        .bus_awready    (bus_awready),
        .bus_wdata      (bus_wdata),
        .bus_wstrb      (bus_wstrb),
        .bus_wready     (bus_wready),
        .bus_wuser_id   (bus_wuser_id),
        .bus_wuser_last (bus_wuser_last),
        .grant          (grant),
        .burst_done     (burst_done),
        .len_err        (len_err)
`ifdef WR_ARB_TIMEOUT_EN
        ,
        .timeout_err    (timeout_err)
`endif
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [3:0]    id;
        logic          ap;
        logic [N-1:0]  gnt;
    } aw_exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [3:0]    strb;
        logic [N-1:0]  wready;
        logic [N-1:0]  wlast;
        logic          done;
    } w_exp_t;

    aw_exp_t aw_q[$];
    w_exp_t  w_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int r);
        logic [N-1:0] v;
        v = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    task automatic issue(input int r, input logic [AW-1:0] a, input logic [LW-1:0] l,
                         input logic [3:0] id, input logic ap);
        aw_exp_t e;
        req_awvalid[r]   = 1'b1;
        req_awaddr[r]    = a;
        req_awlen[r]     = l;
        req_awuser_id[r] = id;
        req_awuser_ap[r] = ap;
        e = '{a, l, id, ap, onehot(r)};
        aw_q.push_back(e);
    endtask

    task automatic wait_aw();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_awvalid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("wait_awvalid", 64'(ok), 64'd1);
    endtask

    task automatic accept_aw(input int r);
        bus_awready = 1'b1;
        @(posedge clk);
        #1;
        bus_awready    = 1'b0;
        req_awvalid[r] = 1'b0;
    endtask

    task automatic beat(input int r, input logic [DW-1:0] d, input logic last,
                        input logic [3:0] bid, input logic exp_done);
        w_exp_t e;
        req_wdata[r]   = d;
        req_wstrb[r]   = d[3:0];
        bus_wready     = 1'b1;
        bus_wuser_last = last;
        bus_wuser_id   = bid;
        e = '{d, d[3:0], onehot(r), last ? onehot(r) : '0, exp_done};
        w_q.push_back(e);
        @(posedge clk);
        #1;
        bus_wready     = 1'b0;
        bus_wuser_last = 1'b0;
    endtask

    task automatic serve(input int r, input int nb, input logic [3:0] id);
        wait_aw();
        accept_aw(r);
        for (int i = 0; i < nb; i++) begin
            beat(r, 32'hC000_0000 | (r << 16) | i, i == nb - 1, id, i == nb - 1);
        end
    endtask

    always @(negedge clk) begin
        aw_exp_t ae;
        w_exp_t  we;
        if (rst_n) begin
            if (bus_awvalid && bus_awready) begin
                if (aw_q.size() == 0) begin
                    chk("aw_unexpected", 64'd1, 64'd0);
                end else begin
                    ae = aw_q.pop_front();
                    chk("awaddr", 64'(bus_awaddr), 64'(ae.addr));
                    chk("awlen", 64'(bus_awlen), 64'(ae.len));
                    chk("awid", 64'(bus_awuser_id), 64'(ae.id));
                    chk("awap", 64'(bus_awuser_ap), 64'(ae.ap));
                    chk("aw_grant", 64'(grant), 64'(ae.gnt));
                    chk("req_awready", 64'(req_awready), 64'(ae.gnt));
                end
            end
            if (bus_wready && grant != '0) begin
                if (w_q.size() == 0) begin
                    chk("w_unexpected", 64'd1, 64'd0);
                end else begin
                    we = w_q.pop_front();
                    chk("wdata", 64'(bus_wdata), 64'(we.data));
                    chk("wstrb", 64'(bus_wstrb), 64'(we.strb));
                    chk("req_wready", 64'(req_wready), 64'(we.wready));
                    chk("req_wlast", 64'(req_wlast), 64'(we.wlast));
                    chk("burst_done", 64'(burst_done), 64'(we.done));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_awvalid", 64'(bus_awvalid), 64'd0);
        chk("rst_awaddr", 64'(bus_awaddr), 64'd0);
        chk("rst_req_awready", 64'(req_awready), 64'd0);
        chk("rst_req_wready", 64'(req_wready), 64'd0);
        chk("rst_burst_done", 64'(burst_done), 64'd0);
        chk("rst_len_err", 64'(len_err), 64'd0);
        rst_n = 1'b1;

        // Single requester, awready on the second ADDR cycle, 4 beats.
        issue(0, 28'h123_4560, 4'd3, WidFc, 1'b1);
        @(posedge clk);
        #1;
        chk("t1_awvalid_lat", 64'(bus_awvalid), 64'd1);
        chk("t1_grant", 64'(grant), 64'b0001);
        @(posedge clk);
        #1;
        accept_aw(0);
        for (int i = 0; i < 4; i++) begin
            beat(0, 32'hA000_0000 + i, i == 3, WidFc, i == 3);
        end
        chk("t1_grant_after", 64'(grant), 64'd0);
        chk("t1_len_err", 64'(len_err), 64'd0);

        // Simultaneous 1 and 2: 1 first, then 2; pointer wraps so 1 wins again.
        issue(1, 28'h200_0000, 4'd1, WidConv, 1'b0);
        issue(2, 28'h300_0000, 4'd0, WidPool, 1'b0);
        serve(1, 2, WidConv);
        chk("t2_idle_gap", 64'(bus_awvalid), 64'd0);
        @(posedge clk);
        #1;
        chk("t2_rel_to_aw", 64'(bus_awvalid), 64'd1);
        chk("t2_grant2", 64'(grant), 64'b0100);
        serve(2, 1, WidPool);
        issue(1, 28'h200_0040, 4'd1, WidConv, 1'b1);
        issue(2, 28'h300_0040, 4'd0, WidPool, 1'b0);
        serve(1, 2, WidConv);
        serve(2, 1, WidPool);
        chk("t2_len_err", 64'(len_err), 64'd0);

        // Short burst sets len_err, which stays set across a good burst.
        issue(3, 28'h0AB_CDE0, 4'd3, 4'h1, 1'b0);
        wait_aw();
        accept_aw(3);
        beat(3, 32'h3333_0000, 1'b0, 4'h1, 1'b0);
        beat(3, 32'h3333_0001, 1'b1, 4'h1, 1'b1);
        chk("t3_len_err_set", 64'(len_err), 64'd1);
        issue(0, 28'h010_0000, 4'd1, WidFc, 1'b0);
        serve(0, 2, WidFc);
        chk("t3_len_err_sticky", 64'(len_err), 64'd1);

        // Last flag with a foreign ID does not release the grant.
        issue(0, 28'h011_0000, 4'd1, WidFc, 1'b1);
        wait_aw();
        accept_aw(0);
        beat(0, 32'h4444_0000, 1'b0, WidFc, 1'b0);
        beat(0, 32'h4444_0001, 1'b1, 4'h5, 1'b0);
        chk("t4_grant_held", 64'(grant), 64'b0001);
        beat(0, 32'h4444_0002, 1'b1, WidFc, 1'b1);
        chk("t4_grant_released", 64'(grant), 64'd0);

        // Reset during beat 2 of a burst.
        issue(2, 28'h050_0000, 4'd3, WidPool, 1'b0);
        wait_aw();
        accept_aw(2);
        beat(2, 32'h5555_0000, 1'b0, WidPool, 1'b0);
        req_wdata[2] = 32'h5555_0001;
        bus_wready   = 1'b1;
        rst_n        = 1'b0;
        #1;
        chk("t5_grant", 64'(grant), 64'd0);
        chk("t5_req_wready", 64'(req_wready), 64'd0);
        chk("t5_wdata", 64'(bus_wdata), 64'd0);
        chk("t5_burst_done", 64'(burst_done), 64'd0);
        @(posedge clk);
        #1;
        bus_wready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t5_len_err_cleared", 64'(len_err), 64'd0);
        issue(3, 28'h060_0000, 4'd0, 4'h3, 1'b1);
        serve(3, 1, 4'h3);
        chk("t5_grant_after", 64'(grant), 64'd0);

`ifdef WR_ARB_TIMEOUT_EN
        // Stalled data phase aborts after 16 cycles; requester 3 is granted next.
        issue(2, 28'h070_0000, 4'd1, WidPool, 1'b0);
        issue(3, 28'h080_0000, 4'd0, 4'h3, 1'b0);
        wait_aw();
        accept_aw(2);
        repeat (15) @(posedge clk);
        #1;
        chk("t6_grant_stalled", 64'(grant), 64'b0100);
        chk("t6_no_timeout_yet", 64'(timeout_err), 64'd0);
        @(posedge clk);
        #1;
        chk("t6_abort_grant", 64'(grant), 64'd0);
        chk("t6_timeout_err", 64'(timeout_err), 64'd1);
        chk("t6_abort_awvalid", 64'(bus_awvalid), 64'd0);
        serve(3, 1, 4'h3);
        chk("t6_timeout_sticky", 64'(timeout_err), 64'd1);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("aw_queue_drained", 64'(aw_q.size()), 64'd0);
        chk("w_queue_drained", 64'(w_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
